pipeline_input_arbiter: RTL
===========================

# pipeline_input_arbiter

Shares the single input port of the pipelined state controller between `N_REQ` requesters, such as vertex, raster and clear command sources. The arbiter picks one pending requester, latches its state vector and acknowledges it, then offers the vector to the pipeline until the pipeline accepts it. It sits directly in front of the pipeline's `state_vars_next` / `state_vars_next_valid` / `state_accepted` handshake. Offers are single-cycle pulses, so a registered accept can never cause a duplicate push.

## Interface
- `N_REQ`, 4: number of requesters; must be ≥2.
- `STATE_VARS_WIDTH`, 8: width of one state vector; matches the pipeline.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester k has a vector pending.
- `req_vars`  in  N_REQ×STATE_VARS_WIDTH  packed vectors; index k is requester k.
- `req_ack`  out  N_REQ  one-hot, 1-cycle pulse: requester k's vector was latched.
- `pipe_vars`  out  STATE_VARS_WIDTH  goes to pipeline `state_vars_next`.
- `pipe_valid`  out  1  goes to pipeline `state_vars_next_valid`.
- `pipe_accepted`  in  1  comes from pipeline `state_accepted` (registered, high the cycle after a push).
- `grant_idx`  out  $clog2(N_REQ)  index of the requester whose vector is currently held.
- `busy`  out  1  a latched vector is not yet accepted.

## Operation
- FSM states: `ARB_IDLE`, `ARB_OFFER`, `ARB_CHECK`. All outputs are registered.
- **ARB_IDLE**
  - If any `req_valid` is set, pick winner k.
  - Latch `pipe_vars` ← `req_vars[k]` and `grant_idx` ← k.
  - Pulse `req_ack[k]`, set `pipe_valid` ← 1 and `busy` ← 1, then go to OFFER.
- **ARB_OFFER**
  - `pipe_valid` is high for exactly this one cycle.
  - Next state is CHECK, with `pipe_valid` ← 0.
- **ARB_CHECK** samples `pipe_accepted`:
  - 0: the pipeline was full. Re-offer the same vector: `pipe_valid` ← 1, go to OFFER.
  - 1 with any `req_valid`: grant the next winner exactly as in IDLE, go to OFFER.
  - 1 with no `req_valid`: clear `busy` and `pipe_valid`, go to IDLE.
- `req_valid` is sampled only in IDLE, or in CHECK when `pipe_accepted` is 1.
- A requester may drop `req_valid` or change `req_vars` freely in the cycle `req_ack` is high. It need not hold data after the ack.
- Winner selection:
  - The search starts at pointer `rr_ptr`.
  - After a grant to k, `rr_ptr` ← (k+1) mod N_REQ.
- `pipe_vars` holds its value outside grants; it is not zeroed after acceptance.

## Timing
- Reset values: state `ARB_IDLE`, `req_ack`=0, `pipe_vars`=0, `pipe_valid`=0, `grant_idx`=0, `busy`=0, `rr_ptr`=0.
- Cycle t (IDLE, request present) → t+1: `req_ack` and `pipe_valid` high → t+2: CHECK → t+3: `pipe_valid` high again, for either the re-offer or the next grant.
- Best-case throughput is 1 vector per 2 cycles. Request-to-pipeline latency is 1 cycle.
- `pipe_valid` is never high on two consecutive cycles.
- `req_ack` is never high on two consecutive cycles for the same requester.
- Reset asserted mid-offer drops the latched vector without acking again. The requester was already acked, so that vector is lost by design.
- A back-pressured pipeline causes OFFER/CHECK to alternate indefinitely. New requests wait, and `rr_ptr` does not move.

## Configuration
- `PIPE_ARB_ROUND_ROBIN_EN` defined: round-robin selection as described above.
- `PIPE_ARB_ROUND_ROBIN_EN` undefined: fixed priority, lowest set index wins. `rr_ptr` is removed and always reads 0.

## Structure
- Package `pipe_arb_pkg` holds:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_OFFER, ARB_CHECK} arb_state_t`
  - shared localparam defaults for `N_REQ` and `STATE_VARS_WIDTH`.
- Sub-module `rr_priority_pick` is a combinational masked, rotating first-one finder.
  - Inputs: `req`, `ptr`. Outputs: `idx`, `found`.
  - With the round-robin macro undefined, `ptr` is tied to 0.

## Test plan
- **Single request:** `req_valid`=4'b0100, `req_vars[2]`=8'hA5, pipeline empty → `req_ack`=4'b0100 and `pipe_valid`=1 with `pipe_vars`=8'hA5 one cycle later; `pipe_accepted`=1 in CHECK; return to IDLE with `busy`=0.
- **Round-robin fairness:** all four requesters held valid → grants in order 0,1,2,3,0, one every 2 cycles. Without the macro: 0,0,0,…
- **Back-pressure:** `pipe_accepted` held 0 for 5 checks → `pipe_valid` toggles 1,0 five times with `pipe_vars` stable; no new `req_ack`; accept on check 6 → next grant.
- **Back-to-back:** requests 1 and 3 pending, accept on first check → `req_ack[3]` asserts in the same cycle as `pipe_valid` for vector 3 (grant taken directly from CHECK); the arbiter does not return to IDLE in between.
- **Async reset mid-offer:** `rst_n` low during OFFER → all outputs 0 immediately without waiting for a clock edge; `rr_ptr`=0; the first grant after reset goes to the lowest pending index.
- **Protocol check:** assertion across all tests that `pipe_valid` is never high on consecutive cycles and `req_ack` is always one-hot or zero.

Source files
------------

// File: rtl/pipeline_input_arbiter_pkg.sv
// +-----------------------------------------------------------------------+
// | pipe_arb_pkg: shared types and defaults for pipeline_input_arbiter     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

package pipe_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OFFER = 2'd1,
    ARB_CHECK = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEF            = 4;
  localparam int STATE_VARS_WIDTH_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/pipeline_input_arbiter_rr_priority_pick.sv
// +-----------------------------------------------------------------------+
// | rr_priority_pick: rotating first-one finder starting at ptr            |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_priority_pick
  import pipe_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     found
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] w_pos;

  // Scan N_REQ positions beginning at ptr, wrapping modulo N_REQ.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    w_pos = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pos = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_input_arbiter.sv
// +-----------------------------------------------------------------------+
// | pipeline_input_arbiter: N_REQ-way arbiter feeding one pipeline input   |
// | Option macro: PIPE_ARB_ROUND_ROBIN_EN (else fixed lowest-index prio)   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module pipeline_input_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int N_REQ            = N_REQ_DEF,
  parameter int STATE_VARS_WIDTH = STATE_VARS_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*STATE_VARS_WIDTH-1:0] req_vars,
  output logic [N_REQ-1:0]                  req_ack,
  output logic [STATE_VARS_WIDTH-1:0]       pipe_vars,
  output logic                              pipe_valid,
  input  logic                              pipe_accepted,
  output logic [$clog2(N_REQ)-1:0]          grant_idx,
  output logic                              busy
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       r_state;
  logic [IDX_W-1:0] w_ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_grant;

  rr_priority_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (w_ptr),
    .idx   (w_idx),
    .found (w_found)
  );

  // Requests are only looked at when idle or right after an accepted offer.
  assign w_grant = w_found &&
                   ((r_state == ARB_IDLE) || (r_state == ARB_CHECK && pipe_accepted));

`ifdef PIPE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      req_ack    <= '0;
      pipe_vars  <= '0;
      pipe_valid <= 1'b0;
      grant_idx  <= '0;
      busy       <= 1'b0;
    end else begin
      req_ack    <= '0;
      pipe_valid <= 1'b0;
      if (w_grant) begin
        pipe_vars  <= req_vars[w_idx*STATE_VARS_WIDTH +: STATE_VARS_WIDTH];
        grant_idx  <= w_idx;
        req_ack    <= N_REQ'(1) << w_idx;
        pipe_valid <= 1'b1;
        busy       <= 1'b1;
        r_state    <= ARB_OFFER;
      end else begin
        case (r_state)
          ARB_OFFER: r_state <= ARB_CHECK;
          ARB_CHECK: begin
            if (!pipe_accepted) begin
              // Pipeline was full: offer the same vector again.
              pipe_valid <= 1'b1;
              r_state    <= ARB_OFFER;
            end else begin
              busy    <= 1'b0;
              r_state <= ARB_IDLE;
            end
          end
          default: r_state <= ARB_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
